// File: rtl/dpwm_pkg.sv
// dpwm_pkg: shared constants, FSM state encoding and ramp helper for the
// DPWM duty-cycle controller.
//   CMP_WIDTH  - width of the PWM compare value / counter
//   STEP_SIZE  - compare counts per duty step
//   MAX_STEP   - highest step index (MAX_STEP*STEP_SIZE fits CMP_WIDTH)
package dpwm_pkg;

    localparam int CMP_WIDTH = 8;
    localparam int STEP_SIZE = 25;
    localparam int MAX_STEP  = 10;

    typedef enum logic [1:0] {
        ST_DEAD       = 2'd0,
        ST_RUN_BUCK   = 2'd1,
        ST_RUN_BRIDGE = 2'd2
    } dpwm_state_e;

    // One ramp step of cur toward tgt, never overshooting the target.
    // Differences are taken before adding/subtracting, so no wrap occurs.
    function automatic logic [CMP_WIDTH-1:0] ramp_toward(
        input logic [CMP_WIDTH-1:0] cur,
        input logic [CMP_WIDTH-1:0] tgt,
        input logic [CMP_WIDTH-1:0] inc
    );
        if (cur < tgt)
            return ((tgt - cur) > inc) ? cur + inc : tgt;
        else if (cur > tgt)
            return ((cur - tgt) > inc) ? cur - inc : tgt;
        else
            return cur;
    endfunction

endpackage

// File: rtl/dpwm_duty_controller_debouncer.sv
// button_debouncer: 2-FF synchroniser, stability counter and press pulse
// for one raw push-button.
//   clk_i    - system clock
//   rst_i    - synchronous reset, active-high
//   btn_i    - raw asynchronous button level
//   press_o  - 1-cycle pulse when an accepted 0->1 transition occurs
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The counter only runs while the synced level disagrees with the
    // accepted level; any agreeing cycle restarts the qualification.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/dpwm_duty_controller.sv
// dpwm_duty_controller: turns debounced up/down buttons into a saturating
// duty step, soft-ramps the PWM compare value at period boundaries and
// sequences the BUCK / Full-Bridge enables with a dead interval.
//   CLK_FPGA_BOARD   - system clock
//   reinicio         - synchronous reset, active-high
//   boton_aumentar   - raw increase button (async)
//   boton_disminuir  - raw decrease button (async)
//   seleccion_salida - 0 = BUCK, 1 = Full-Bridge (async)
//   pwm_period_end   - 1-cycle strobe at PWM counter wrap
//   duty_cmp         - compare value for the PWM comparator
//   duty_step        - current step index 0..MAX_STEP
//   enable_buck      - BUCK gate enable
//   enable_bridge    - Full-Bridge gate enable
module dpwm_duty_controller
    import dpwm_pkg::*;
#(
    parameter int RAMP_INC        = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEAD_PERIODS    = 2
) (
    input  logic                 CLK_FPGA_BOARD,
    input  logic                 reinicio,
    input  logic                 boton_aumentar,
    input  logic                 boton_disminuir,
    input  logic                 seleccion_salida,
    input  logic                 pwm_period_end,
    output logic [CMP_WIDTH-1:0] duty_cmp,
    output logic [3:0]           duty_step,
    output logic                 enable_buck,
    output logic                 enable_bridge
);

    localparam int DCW = $clog2(DEAD_PERIODS + 1);

    logic inc_pulse, dec_pulse;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk_i   (CLK_FPGA_BOARD),
        .rst_i   (reinicio),
        .btn_i   (boton_aumentar),
        .press_o (inc_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk_i   (CLK_FPGA_BOARD),
        .rst_i   (reinicio),
        .btn_i   (boton_disminuir),
        .press_o (dec_pulse)
    );

    logic [1:0]           sel_sync_q;
    logic                 sel_last_q;
    logic                 sel_s;
    logic [3:0]           step_q, step_d;
    logic [CMP_WIDTH-1:0] cmp_q, cmp_d;
    logic [CMP_WIDTH-1:0] target;
    logic [DCW-1:0]       dead_cnt_q, dead_cnt_d;
    dpwm_state_e          state_q, state_d;
    logic                 en_buck_q, en_bridge_q;

    assign sel_s = sel_sync_q[1];

    // Step register: simultaneous presses cancel out.
    always_comb begin
        step_d = step_q;
        if (inc_pulse && !dec_pulse && step_q != 4'(MAX_STEP))
            step_d = step_q + 4'd1;
        else if (dec_pulse && !inc_pulse && step_q != 4'd0)
            step_d = step_q - 4'd1;
    end

    // Product is formed wide, then truncated; MAX_STEP*STEP_SIZE fits CMP_WIDTH.
    assign target = CMP_WIDTH'((CMP_WIDTH + 4)'(step_q) * (CMP_WIDTH + 4)'(STEP_SIZE));

    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        cmp_d      = cmp_q;
        case (state_q)
            ST_DEAD: begin
                // A selection change mid-dead restarts the full interval.
                if (sel_s != sel_last_q) begin
                    dead_cnt_d = '0;
                end else if (pwm_period_end) begin
                    if (dead_cnt_q == DCW'(DEAD_PERIODS - 1)) begin
                        state_d    = sel_s ? ST_RUN_BRIDGE : ST_RUN_BUCK;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN_BUCK: begin
                if (sel_s)               state_d = ST_DEAD;
                else if (pwm_period_end) cmp_d = ramp_toward(cmp_q, target, CMP_WIDTH'(RAMP_INC));
            end
            ST_RUN_BRIDGE: begin
                if (!sel_s)              state_d = ST_DEAD;
                else if (pwm_period_end) cmp_d = ramp_toward(cmp_q, target, CMP_WIDTH'(RAMP_INC));
            end
            default: begin
                state_d    = ST_DEAD;
                dead_cnt_d = '0;
            end
        endcase
        // Leaving RUN drops the compare value immediately so every
        // restart ramps up from zero.
        if (state_d == ST_DEAD) cmp_d = '0;
    end

    always_ff @(posedge CLK_FPGA_BOARD) begin
        if (reinicio) begin
            sel_sync_q  <= '0;
            sel_last_q  <= 1'b0;
            step_q      <= '0;
            cmp_q       <= '0;
            dead_cnt_q  <= '0;
            state_q     <= ST_DEAD;
            en_buck_q   <= 1'b0;
            en_bridge_q <= 1'b0;
        end else begin
            sel_sync_q  <= {sel_sync_q[0], seleccion_salida};
            sel_last_q  <= sel_s;
            step_q      <= step_d;
            cmp_q       <= cmp_d;
            dead_cnt_q  <= dead_cnt_d;
            state_q     <= state_d;
            // Enables are decoded from the next state so they are glitch-free
            // registers and can never both be high.
            en_buck_q   <= (state_d == ST_RUN_BUCK);
            en_bridge_q <= (state_d == ST_RUN_BRIDGE);
        end
    end

    assign duty_cmp      = cmp_q;
    assign duty_step     = step_q;
    assign enable_buck   = en_buck_q;
    assign enable_bridge = en_bridge_q;

endmodule

// File: tb/tb_dpwm_duty_controller.sv
// Scoreboard bench for dpwm_duty_controller. Stimulus pushes the expected
// sequence of value changes on duty_step, duty_cmp and the enable pair; an
// independent negedge monitor pops an entry each time an output changes.
module tb_dpwm_duty_controller;

    localparam int RAMP_INC     = 5;
    localparam int STEP_SIZE    = 25;
    localparam int MAX_STEP     = 10;
    localparam int DEAD_PERIODS = 2;
    localparam int PERIOD       = 16;

    logic       clk = 1'b0;
    logic       reinicio = 1'b1;
    logic       boton_aumentar = 1'b0, boton_disminuir = 1'b0;
    logic       seleccion_salida = 1'b0;
    logic       pwm_period_end = 1'b0;
    logic [7:0] duty_cmp;
    logic [3:0] duty_step;
    logic       enable_buck, enable_bridge;

    dpwm_duty_controller #(
        .RAMP_INC(RAMP_INC), .DEBOUNCE_CYCLES(4), .DEAD_PERIODS(DEAD_PERIODS)
    ) dut (
        .CLK_FPGA_BOARD   (clk),
        .reinicio         (reinicio),
        .boton_aumentar   (boton_aumentar),
        .boton_disminuir  (boton_disminuir),
        .seleccion_salida (seleccion_salida),
        .pwm_period_end   (pwm_period_end),
        .duty_cmp         (duty_cmp),
        .duty_step        (duty_step),
        .enable_buck      (enable_buck),
        .enable_bridge    (enable_bridge)
    );

    always #5 clk = ~clk;

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            ph = (ph + 1) % PERIOD;
            pwm_period_end = (ph == PERIOD - 1);
        end
    end

    int total = 0, bad = 0;
    int cmp_q[$], step_q[$], en_q[$];
    int m_step = 0, m_tail = 0;
    bit mon_en = 0, started = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic [7:0] prev_cmp;
    logic [3:0] prev_step;
    logic [1:0] prev_en;
    int         dead_strobes = 0;
    bit         prev_strobe = 0;

    always @(negedge clk) begin
        logic [1:0] en_now;
        en_now = {enable_bridge, enable_buck};
        if (started && !reinicio)
            chk("enables_exclusive", int'(enable_buck & enable_bridge), 0);
        if (mon_en) begin
            if (duty_step !== prev_step) begin
                if (step_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL duty_step: unexpected change to %0d", duty_step);
                end else chk("duty_step", int'(duty_step), step_q.pop_front());
            end
            if (duty_cmp !== prev_cmp) begin
                if (cmp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL duty_cmp: unexpected change to %0d", duty_cmp);
                end else chk("duty_cmp", int'(duty_cmp), cmp_q.pop_front());
            end
            if (en_now !== prev_en) begin
                if (en_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL enables: unexpected change to %0d", en_now);
                end else chk("enables", int'(en_now), en_q.pop_front());
                if (prev_en == 2'b00 && en_now != 2'b00) begin
                    chk("dead_strobes", dead_strobes, DEAD_PERIODS);
                    chk("run_after_strobe", int'(prev_strobe), 1);
                end
            end
        end
        if (reinicio || en_now != 2'b00) dead_strobes = 0;
        else if (pwm_period_end)         dead_strobes++;
        prev_strobe = pwm_period_end && !reinicio;
        prev_cmp  = duty_cmp;
        prev_step = duty_step;
        prev_en   = en_now;
    end

    // ---------------- reference model ----------------
    // Push the compare values the ramp must pass through from the current
    // tail toward the target of the model step.
    task automatic push_ramp();
        int tgt;
        tgt = m_step * STEP_SIZE;
        while (m_tail != tgt) begin
            if (m_tail < tgt) m_tail = (tgt - m_tail > RAMP_INC) ? m_tail + RAMP_INC : tgt;
            else              m_tail = (m_tail - tgt > RAMP_INC) ? m_tail - RAMP_INC : tgt;
            cmp_q.push_back(m_tail);
        end
    endtask

    task automatic model_press(input int delta);
        int nxt;
        nxt = m_step + delta;
        if (nxt > MAX_STEP) nxt = MAX_STEP;
        if (nxt < 0)        nxt = 0;
        if (nxt != m_step) begin
            m_step = nxt;
            step_q.push_back(nxt);
            push_ramp();
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic do_reset(input int n);
        mon_en = 0;
        @(posedge clk); #1;
        reinicio = 1; boton_aumentar = 0; boton_disminuir = 0; seleccion_salida = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("rst_duty_cmp", int'(duty_cmp), 0);
            chk("rst_duty_step", int'(duty_step), 0);
            chk("rst_enables", int'({enable_bridge, enable_buck}), 0);
        end
        reinicio = 0;
        cmp_q.delete(); step_q.delete(); en_q.delete();
        m_step = 0; m_tail = 0;
        en_q.push_back(1);
        started = 1;
        @(negedge clk); #1;
        mon_en = 1;
    endtask

    task automatic press(input bit inc, input bit dec, input int hold);
        @(posedge clk); #1;
        boton_aumentar = inc; boton_disminuir = dec;
        model_press(int'(inc) - int'(dec));
        repeat (hold) @(posedge clk);
        #1; boton_aumentar = 0; boton_disminuir = 0;
        repeat ($urandom_range(8, 14)) @(posedge clk);
    endtask

    task automatic settle();
        int n = 0;
        while ((cmp_q.size() + step_q.size() + en_q.size()) != 0 && n < 4000) begin
            @(posedge clk); n++;
        end
        if (n >= 4000) begin
            total++; bad++;
            $display("FAIL settle_timeout: pending cmp=%0d step=%0d en=%0d expected 0",
                     cmp_q.size(), step_q.size(), en_q.size());
            cmp_q.delete(); step_q.delete(); en_q.delete();
        end
        repeat (40) @(posedge clk);
    endtask

    task automatic switch_sel(input bit s);
        @(posedge clk); #1;
        seleccion_salida = s;
        en_q.push_back(0);
        if (m_tail != 0) cmp_q.push_back(0);
        en_q.push_back(s ? 2 : 1);
        m_tail = 0;
        push_ramp();
        repeat (4) @(posedge clk);
        #1;
        chk("switch_old_enable_off", int'(s ? enable_buck : enable_bridge), 0);
        chk("switch_cmp_zero", int'(duty_cmp), 0);
    endtask

    initial begin
        // 1. reset and start-up into BUCK
        do_reset(3);
        settle();
        chk("startup_buck", int'(enable_buck), 1);
        chk("startup_bridge", int'(enable_bridge), 0);

        // 2. single long press: one step, ramp 5..25
        press(1, 0, 20);
        settle();
        chk("single_step", int'(duty_step), 1);
        chk("single_cmp", int'(duty_cmp), 25);

        // 3. bouncing input must be rejected
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 boton_aumentar = (i % 2 == 0);
            repeat (2) @(posedge clk);
        end
        #1 boton_aumentar = 0;
        repeat (12) @(posedge clk);
        settle();
        chk("bounce_step", int'(duty_step), 1);

        // 4. saturation up, down, and simultaneous presses
        for (int i = 0; i < 12; i++) press(1, 0, $urandom_range(8, 14));
        settle();
        chk("sat_up_step", int'(duty_step), MAX_STEP);
        chk("sat_up_cmp", int'(duty_cmp), MAX_STEP * STEP_SIZE);
        for (int i = 0; i < 12; i++) press(0, 1, $urandom_range(8, 14));
        settle();
        chk("sat_dn_step", int'(duty_step), 0);
        chk("sat_dn_cmp", int'(duty_cmp), 0);
        for (int i = 0; i < 4; i++) press(1, 0, $urandom_range(8, 14));
        settle();
        press(1, 1, 10);
        settle();
        chk("simul_step", int'(duty_step), 4);
        chk("simul_cmp", int'(duty_cmp), 100);

        // 5. output switch to Full-Bridge
        switch_sel(1);
        settle();
        chk("bridge_on", int'(enable_bridge), 1);
        chk("bridge_cmp", int'(duty_cmp), 100);

        // random up/down bursts, each settled before the direction changes
        for (int p = 0; p < 6; p++) begin
            bit up;
            int cnt;
            up  = bit'($urandom_range(0, 1));
            cnt = $urandom_range(1, 4);
            for (int k = 0; k < cnt; k++) press(up, !up, $urandom_range(8, 14));
            settle();
            chk("rand_step", int'(duty_step), m_step);
        end
        switch_sel(0);
        settle();

        // 6. reset mid-ramp at duty_cmp == 15
        while (m_step > 0) press(0, 1, $urandom_range(8, 14));
        settle();
        press(1, 0, 10);
        begin
            int n = 0;
            while (duty_cmp != 8'd15 && n < 2000) begin @(negedge clk); n++; end
            if (n >= 2000) begin
                total++; bad++;
                $display("FAIL wait_cmp15: got %0d expected 15", duty_cmp);
            end
        end
        do_reset(1);
        settle();
        press(1, 0, 10);
        settle();
        chk("restart_cmp", int'(duty_cmp), STEP_SIZE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
